// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between NREQ byte-stream requesters.
// Grant is locked for a whole packet (until WLAST) and bytes are paced by TX_BUSY.
// Optional mid-packet grant timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NREQ-1:0]   REQ,
    input  logic [8*NREQ-1:0] WDATA,
    input  logic [NREQ-1:0]   WLAST,
    output logic [NREQ-1:0]   GNT,
    output logic [NREQ-1:0]   ACK,
    output logic [7:0]        TX_DATA,
    output logic              TX_START,
    input  logic              TX_BUSY,
    output logic              ERR
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, OWN, WAIT_HI, WAIT_LO} state_t;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   last_owner, last_owner_nxt;
    logic [IW-1:0]   pick;
    logic [IW:0]     cand;
    logic            any_req;
    logic            last_r, last_r_nxt;
    logic            tx_start_nxt;
    logic [NREQ-1:0] gnt_nxt, ack_nxt;
    logic [7:0]      tx_data_nxt;
    logic [7:0]      wbyte [NREQ];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          err_nxt;
`endif

    genvar i;
    for (i = 0; i < NREQ; i++) begin : g_wbyte
        assign wbyte[i] = WDATA[8*i +: 8];
    end

    // Round-robin search: first requester above last_owner, wrapping; smallest distance wins
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, last_owner} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (REQ[cand[IW-1:0]]) begin
                pick    = cand[IW-1:0];
                any_req = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every register holds unless a state acts on it
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        last_r_nxt     = last_r;
        gnt_nxt        = GNT;
        ack_nxt        = '0;
        tx_start_nxt   = 1'b0;
        tx_data_nxt    = TX_DATA;
`ifdef UART_ARB_TIMEOUT_EN
        tcnt_nxt       = tcnt;
        err_nxt        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_nxt      = pick;
                    gnt_nxt        = '0;
                    gnt_nxt[pick]  = 1'b1;
                    state_nxt      = OWN;
`ifdef UART_ARB_TIMEOUT_EN
                    tcnt_nxt       = '0;
`endif
                end
            end
            OWN: begin
                if (REQ[owner] && !TX_BUSY) begin
                    tx_data_nxt    = wbyte[owner];
                    tx_start_nxt   = 1'b1;
                    ack_nxt[owner] = 1'b1;
                    last_r_nxt     = WLAST[owner];
                    state_nxt      = WAIT_HI;
`ifdef UART_ARB_TIMEOUT_EN
                    tcnt_nxt       = '0;
                end else if (!REQ[owner]) begin
                    if (tcnt == TW'(TIMEOUT_CYCLES)) begin
                        gnt_nxt        = '0;
                        err_nxt        = 1'b1;
                        last_owner_nxt = owner;
                        state_nxt      = IDLE;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
`endif
                end
            end
            WAIT_HI: begin
                if (TX_BUSY)
                    state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (last_r) begin
                        gnt_nxt        = '0;
                        last_owner_nxt = owner;
                        state_nxt      = IDLE;
                    end else begin
                        state_nxt      = OWN;
`ifdef UART_ARB_TIMEOUT_EN
                        tcnt_nxt       = '0;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset makes the last requester the previous owner so 0 wins first
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            last_r     <= 1'b0;
            GNT        <= '0;
            ACK        <= '0;
            TX_DATA    <= 8'h00;
            TX_START   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tcnt       <= '0;
            ERR        <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            last_r     <= last_r_nxt;
            GNT        <= gnt_nxt;
            ACK        <= ack_nxt;
            TX_DATA    <= tx_data_nxt;
            TX_START   <= tx_start_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            tcnt       <= tcnt_nxt;
            ERR        <= err_nxt;
`endif
        end
    end

`ifndef UART_ARB_TIMEOUT_EN
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with requester and transmitter models.
module tb_uart_tx_arbiter;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  REQ;
    logic [31:0] WDATA;
    logic [3:0]  WLAST;
    logic [3:0]  GNT;
    logic [3:0]  ACK;
    logic [7:0]  TX_DATA;
    logic        TX_START;
    logic        TX_BUSY;
    logic        ERR;

    int errors = 0;
    int checks = 0;

    logic [9:0] sb [$];
    logic [8:0] pkt [4][16];
    int         pp [4];
    int         pn [4];
    int         busy_len = 20;
    int         bcnt = 0;
    logic       force_busy = 1'b0;
    int         start_cnt = 0;
    int         err_cnt = 0;
    int         err_cycles = 0;
    logic       err_prev = 1'b0;
    logic [9:0] e;
    logic [3:0] oh;

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(10)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WDATA(WDATA), .WLAST(WLAST),
        .GNT(GNT), .ACK(ACK), .TX_DATA(TX_DATA), .TX_START(TX_START),
        .TX_BUSY(TX_BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic load(input int r, input logic [7:0] b, input logic l);
        pkt[r][pn[r]] = {l, b};
        pn[r]++;
    endtask

    task automatic push(input logic [1:0] r, input logic [7:0] b);
        sb.push_back({r, b});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        step();
        while ((sb.size() != 0 || GNT != 4'd0 || TX_BUSY || REQ != 4'd0) && n < 2000) begin
            step();
            n++;
        end
        check({tag, "_drain"}, sb.size(), 0);
        check({tag, "_idle_gnt"}, 32'(GNT), 0);
    endtask

    // Requester, transmitter and scoreboard models, all acting mid-cycle
    initial forever begin
        @(negedge CLK);
        if (TX_START || ACK != 4'd0)
            check("ack_with_start", 32'(ACK != 4'd0), 32'(TX_START));
        if (TX_START) begin
            start_cnt++;
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                oh = '0;
                oh[e[9:8]] = 1'b1;
                check("tx_data", 32'(TX_DATA), 32'(e[7:0]));
                check("ack_owner", 32'(ACK), 32'(oh));
                check("gnt_owner", 32'(GNT), 32'(oh));
            end
            bcnt = busy_len;
        end else if (bcnt != 0) begin
            bcnt--;
        end
        TX_BUSY = force_busy || (bcnt != 0);
        if (ERR) err_cycles++;
        if (ERR && !err_prev) err_cnt++;
        err_prev = ERR;
        for (int r = 0; r < 4; r++) begin
            if (ACK[r]) pp[r]++;
            if (pp[r] < pn[r]) begin
                REQ[r] = 1'b1;
                WDATA[8*r +: 8] = pkt[r][pp[r]][7:0];
                WLAST[r] = pkt[r][pp[r]][8];
            end else begin
                REQ[r] = 1'b0;
                WDATA[8*r +: 8] = 8'h00;
                WLAST[r] = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of run");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        int e0;
        logic [31:0] prev;
        RESET = 1'b1;
        REQ = '0;
        WDATA = '0;
        WLAST = '0;
        TX_BUSY = 1'b0;
        for (int r = 0; r < 4; r++) begin
            pp[r] = 0;
            pn[r] = 0;
        end
        repeat (3) step();
        check("rst_gnt", 32'(GNT), 0);
        check("rst_ack", 32'(ACK), 0);
        check("rst_tx_data", 32'(TX_DATA), 0);
        check("rst_tx_start", 32'(TX_START), 0);
        check("rst_err", 32'(ERR), 0);
        RESET = 1'b0;

        // single byte from requester 0, long frame
        busy_len = 20;
        step();
        load(0, 8'hA5, 1'b1);
        push(2'd0, 8'hA5);
        step();
        check("s1_gnt_c1", 32'(GNT), 32'h1);
        check("s1_start_c1", 32'(TX_START), 0);
        step();
        check("s1_start_c2", 32'(TX_START), 1);
        check("s1_ack_c2", 32'(ACK), 32'h1);
        check("s1_data_c2", 32'(TX_DATA), 32'hA5);
        step();
        prev = 32'(GNT);
        n = 0;
        while (TX_BUSY && n < 100) begin
            prev = 32'(GNT);
            step();
            n++;
        end
        check("s1_gnt_before_fall", prev, 32'h1);
        check("s1_gnt_drop", 32'(GNT), 0);
        drain("s1");

        // all four requesters, order restarts at 0 after reset
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        busy_len = 3;
        step();
        load(0, 8'hA0, 1'b1);
        load(0, 8'hA4, 1'b1);
        load(1, 8'hB1, 1'b1);
        load(2, 8'hC2, 1'b1);
        load(3, 8'hD3, 1'b1);
        push(2'd0, 8'hA0);
        push(2'd1, 8'hB1);
        push(2'd2, 8'hC2);
        push(2'd3, 8'hD3);
        push(2'd0, 8'hA4);
        drain("s2");

        // three-byte packet from 1 is locked while 2 waits
        step();
        load(1, 8'h11, 1'b0);
        load(1, 8'h22, 1'b0);
        load(1, 8'h33, 1'b1);
        load(2, 8'h44, 1'b1);
        push(2'd1, 8'h11);
        push(2'd1, 8'h22);
        push(2'd1, 8'h33);
        push(2'd2, 8'h44);
        drain("s3");

        // requester 0 stalls mid-packet while 1 waits
        step();
        load(0, 8'h55, 1'b0);
        load(1, 8'h77, 1'b1);
        push(2'd0, 8'h55);
`ifdef UART_ARB_TIMEOUT_EN
        push(2'd1, 8'h77);
`endif
        e0 = err_cnt;
        s0 = start_cnt;
        n = 0;
        while (start_cnt == s0 && n < 100) begin
            step();
            n++;
        end
        check("s4_first_start", start_cnt - s0, 1);
        repeat (50) step();
`ifdef UART_ARB_TIMEOUT_EN
        check("s4_err_pulses", err_cnt - e0, 1);
`else
        check("s4_err_pulses", err_cnt - e0, 0);
        check("s4_gnt_hold", 32'(GNT), 32'h1);
`endif
        load(0, 8'h66, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        push(2'd0, 8'h66);
`else
        push(2'd0, 8'h66);
        push(2'd1, 8'h77);
`endif
        drain("s4");
        check("err_width", err_cycles, err_cnt);

        // reset during WAIT_LO of a two-byte packet
        busy_len = 20;
        step();
        load(3, 8'h88, 1'b0);
        load(3, 8'h99, 1'b1);
        push(2'd3, 8'h88);
        s0 = start_cnt;
        n = 0;
        while (start_cnt == s0 && n < 100) begin
            step();
            n++;
        end
        check("s5_first_start", start_cnt - s0, 1);
        repeat (4) step();
        #1;
        RESET = 1'b1;
        pp[3] = 0;
        pn[3] = 0;
        #1;
        check("s5_rst_gnt", 32'(GNT), 0);
        check("s5_rst_ack", 32'(ACK), 0);
        check("s5_rst_tx_data", 32'(TX_DATA), 0);
        check("s5_rst_tx_start", 32'(TX_START), 0);
        check("s5_rst_err", 32'(ERR), 0);
        step();
        RESET = 1'b0;
        load(1, 8'hAA, 1'b1);
        load(2, 8'hBB, 1'b1);
        push(2'd1, 8'hAA);
        push(2'd2, 8'hBB);
        step();
        check("s5_gnt_after_rst", 32'(GNT), 32'h2);
        drain("s5");

        // transmitter busy at grant time
        force_busy = 1'b1;
        TX_BUSY = 1'b1;
        step();
        load(0, 8'hC3, 1'b1);
        push(2'd0, 8'hC3);
        s0 = start_cnt;
        repeat (6) step();
        check("s6_no_start", start_cnt - s0, 0);
        check("s6_gnt_hold", 32'(GNT), 32'h1);
        force_busy = 1'b0;
        TX_BUSY = 1'b0;
        step();
        check("s6_start", 32'(TX_START), 1);
        check("s6_ack", 32'(ACK), 32'h1);
        check("s6_data", 32'(TX_DATA), 32'hC3);
        drain("s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
